// File: rtl/mux_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter_4
// Description : Two-requester round-robin arbiter driving a shared registered
//               2:1 data mux, with burst limiting and downstream backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter_4 #(
    parameter int BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic [3:0] a,
    input  logic       req_b,
    input  logic [3:0] b,
    input  logic       out_ready,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       sel,
    output logic       ack_a,
    output logic       ack_b,
    output logic [3:0] c,
    output logic       out_valid
);

    // One bit per grant so gnt_a/gnt_b come straight off the state flops.
    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_GNT_A = 2'b01;
    localparam logic [1:0] c_GNT_B = 2'b10;
    localparam logic [3:0] c_BURST = 4'(BURST);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic [3:0] c_q, c_d;
    logic       valid_q, valid_d;

    logic       w_load;
    logic       w_cap_a;
    logic       w_cap_b;
    logic       w_cap;
    logic       w_burst_done;

    assign w_load       = out_ready | ~valid_q;
    assign w_cap_a      = (state_q == c_GNT_A) & req_a & w_load & ~reset;
    assign w_cap_b      = (state_q == c_GNT_B) & req_b & w_load & ~reset;
    assign w_cap        = w_cap_a | w_cap_b;
    assign w_burst_done = w_cap & ((cnt_q + 4'd1) == c_BURST);

    always_comb begin
        state_d = state_q;
        cnt_d   = w_cap ? (cnt_q + 4'd1) : cnt_q;
        last_d  = last_q;
        c_d     = c_q;
        valid_d = valid_q;

        case (state_q)
            c_IDLE: begin
                if (req_a && req_b) begin
                    state_d = last_q ? c_GNT_B : c_GNT_A;
                end else if (req_a) begin
                    state_d = c_GNT_A;
                end else if (req_b) begin
                    state_d = c_GNT_B;
                end
            end
            c_GNT_A: begin
                if (!req_a) begin
                    state_d = req_b ? c_GNT_B : c_IDLE;
                end else if (w_burst_done) begin
                    if (req_b) begin
                        state_d = c_GNT_B;
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
            end
            c_GNT_B: begin
                if (!req_b) begin
                    state_d = req_a ? c_GNT_A : c_IDLE;
                end else if (w_burst_done) begin
                    if (req_a) begin
                        state_d = c_GNT_A;
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // Entering a grant starts a fresh burst and records who was served.
        if ((state_d != state_q) && (state_d != c_IDLE)) begin
            cnt_d  = 4'd0;
            last_d = (state_d == c_GNT_A);
        end

        if (w_cap) begin
            c_d     = w_cap_a ? a : b;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b0;
            c_q     <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end

    assign gnt_a     = state_q[0];
    assign gnt_b     = state_q[1];
    assign sel       = state_q[0];
    assign ack_a     = w_cap_a;
    assign ack_b     = w_cap_b;
    assign c         = c_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_arbiter_4
// Description : Directed scoreboard bench for mux_arbiter_4 (BURST = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter_4;

    logic       clk;
    logic       reset;
    logic       req_a;
    logic [3:0] a;
    logic       req_b;
    logic [3:0] b;
    logic       out_ready;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic       ack_a;
    logic       ack_b;
    logic [3:0] c;
    logic       out_valid;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    mux_arbiter_4 #(.BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .a         (a),
        .req_b     (req_b),
        .b         (b),
        .out_ready (out_ready),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .c         (c),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every beat accepted downstream is compared against the scoreboard.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got %h expected none at %0t", c, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (c !== e) begin
                        errors++;
                        $display("FAIL beat_data: got %h expected %h at %0t", c, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic owner_a;
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; a = 4'h0; b = 4'h0; out_ready = 1'b0;
        repeat (3) step();
        chk1("rst_gnt_a", gnt_a, 1'b0);
        chk1("rst_gnt_b", gnt_b, 1'b0);
        chk1("rst_sel", sel, 1'b0);
        chk4("rst_c", c, 4'h0);
        chk1("rst_out_valid", out_valid, 1'b0);

        // Tie from reset: A first, then alternate every 4 beats.
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1; a = 4'h3; b = 4'hC; out_ready = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            owner_a = (((k >> 2) & 1) == 0);
            chk1("tie_gnt_a", gnt_a, owner_a);
            chk1("tie_gnt_b", gnt_b, !owner_a);
            chk1("tie_sel", sel, owner_a);
            chk1("tie_ack", owner_a ? ack_a : ack_b, 1'b1);
            chk1("tie_noack_loser", owner_a ? ack_b : ack_a, 1'b0);
            exp_q.push_back(owner_a ? 4'h3 : 4'hC);
            step();
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
        chk1("tie_end_gnt_a", gnt_a, 1'b0);
        chk1("tie_end_gnt_b", gnt_b, 1'b0);
        chk1("tie_end_valid", out_valid, 1'b0);

        // Single requester B: held grant, counter wraps without a gap.
        req_b = 1'b1; b = 4'h9;
        step();
        for (int k = 0; k < 10; k++) begin
            chk1("single_gnt_b", gnt_b, 1'b1);
            chk1("single_gnt_a", gnt_a, 1'b0);
            chk1("single_ack_b", ack_b, 1'b1);
            exp_q.push_back(4'h9);
            step();
        end
        req_b = 1'b0;
        step();
        chk1("single_end_gnt_b", gnt_b, 1'b0);
        chk1("single_end_valid", out_valid, 1'b0);

        // Backpressure on A, then release to IDLE.
        req_a = 1'b1; a = 4'h5;
        step();
        chk1("bp_gnt_a", gnt_a, 1'b1);
        chk1("bp_ack_first", ack_a, 1'b1);
        exp_q.push_back(4'h5);
        out_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            chk1("bp_ack_held", ack_a, 1'b0);
            chk1("bp_valid_held", out_valid, 1'b1);
            chk4("bp_c_held", c, 4'h5);
            if (k < 2) step();
        end
        out_ready = 1'b1; a = 4'h6;
        #1;
        chk1("bp_ack_resume", ack_a, 1'b1);
        exp_q.push_back(4'h6);
        step();
        req_a = 1'b0;
        #1;
        chk1("rel_no_ack", ack_a, 1'b0);
        step();
        chk1("rel_gnt_a", gnt_a, 1'b0);
        chk1("rel_gnt_b", gnt_b, 1'b0);
        chk1("rel_valid", out_valid, 1'b0);
        chk4("rel_c_hold", c, 4'h6);

        // Drop: A leaves after 2 beats while B waits -> straight to B, fresh burst.
        req_a = 1'b1; a = 4'h7;
        step();
        req_b = 1'b1; b = 4'hE;
        #1;
        chk1("drop_gnt_a", gnt_a, 1'b1);
        chk1("drop_ack_a1", ack_a, 1'b1);
        exp_q.push_back(4'h7);
        step();
        chk1("drop_ack_a2", ack_a, 1'b1);
        exp_q.push_back(4'h7);
        step();
        req_a = 1'b0;
        #1;
        chk1("drop_switch_ack_a", ack_a, 1'b0);
        chk1("drop_switch_ack_b", ack_b, 1'b0);
        step();
        chk1("drop_gnt_b", gnt_b, 1'b1);
        chk1("drop_gnt_a_off", gnt_a, 1'b0);
        req_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk1("drop_burst_gnt_b", gnt_b, 1'b1);
            chk1("drop_burst_ack_b", ack_b, 1'b1);
            exp_q.push_back(4'hE);
            step();
        end
        chk1("drop_back_to_a", gnt_a, 1'b1);
        req_a = 1'b0; req_b = 1'b0;
        step();
        chk1("drop_end_valid", out_valid, 1'b0);

        // Reset mid-burst on B; the beat captured just before reset is discarded.
        req_a = 1'b1; req_b = 1'b1; a = 4'h1; b = 4'hB;
        step();
        chk1("mrst_gnt_b", gnt_b, 1'b1);
        exp_q.push_back(4'hB);
        step();
        step();
        chk1("mrst_valid_pre", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk1("mrst_ack_b_gated", ack_b, 1'b0);
        chk1("mrst_ack_a_gated", ack_a, 1'b0);
        step();
        chk1("mrst_gnt_a", gnt_a, 1'b0);
        chk1("mrst_gnt_b0", gnt_b, 1'b0);
        chk1("mrst_sel", sel, 1'b0);
        chk4("mrst_c", c, 4'h0);
        chk1("mrst_valid", out_valid, 1'b0);
        reset = 1'b0;
        step();
        chk1("mrst_tie_gnt_a", gnt_a, 1'b1);
        chk1("mrst_tie_ack_a", ack_a, 1'b1);
        exp_q.push_back(4'h1);
        step();
        req_a = 1'b0; req_b = 1'b0;
        repeat (3) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
